// File: rtl/tennis_pkg.sv
// Shared definitions for the tennis referee: FSM encoding, court sides and
// seven-segment patterns (gfedcba, active-low) plus digit-splitting helpers.
package tennis_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RALLY = 2'd1,
        ST_POINT = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic SIDE_LEFT  = 1'b0;
    localparam logic SIDE_RIGHT = 1'b1;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Digit code that renders as an unlit digit.
    localparam logic [3:0] CODE_BLANK = 4'hF;

    // Map a digit code (0-9, anything else blank) to its segment pattern.
    function automatic logic [6:0] seg_pattern(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // Tens digit of a 0..15 score; a leading zero is blanked.
    function automatic logic [3:0] tens_code(input logic [3:0] value);
        return (value >= 4'd10) ? 4'd1 : CODE_BLANK;
    endfunction

    // Units digit of a 0..15 score.
    function automatic logic [3:0] units_code(input logic [3:0] value);
        return (value >= 4'd10) ? (value - 4'd10) : value;
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// Multiplexed 4-digit seven-segment driver. A divider picks a new digit every
// SCAN_DIV clocks; an and seg are registered and only change on that wrap.
module seg7_scan
    import tennis_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] scan_cnt_reg;
    logic [1:0]    digit_sel_reg;
    logic [1:0]    sel_next;
    logic [3:0]    code_next;
    logic [3:0]    an_next;
    logic [3:0]    an_reg;
    logic [6:0]    seg_reg;

    // Digit that becomes active on the next wrap, and its code.
    always_comb begin
        sel_next  = digit_sel_reg + 2'd1;
        code_next = digit0;
        case (sel_next)
            2'd0: code_next = digit0;
            2'd1: code_next = digit1;
            2'd2: code_next = digit2;
            2'd3: code_next = digit3;
            default: code_next = digit0;
        endcase
    end

    // One active-low enable per digit position.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_an
            assign an_next[gi] = (sel_next != 2'(gi));
        end
    endgenerate

    // Scan divider and registered display outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt_reg  <= '0;
            digit_sel_reg <= 2'd0;
            an_reg        <= 4'b1110;
            seg_reg       <= SEG_0;
        end else if (scan_cnt_reg == SCAN_LAST) begin
            scan_cnt_reg  <= '0;
            digit_sel_reg <= sel_next;
            an_reg        <= an_next;
            seg_reg       <= seg_pattern(code_next);
        end else begin
            scan_cnt_reg  <= scan_cnt_reg + CW'(1);
        end
    end

    assign an  = an_reg;
    assign seg = seg_reg;

endmodule

// File: rtl/tennis_referee.sv
// Tennis referee: judges hits, misses and faults from the ball position and
// paddle pulses, keeps the score, requests serves and drives the display.
module tennis_referee
    import tennis_pkg::*;
#(
    parameter int N_POS      = 8,
    parameter int WIN_SCORE  = 7,
    parameter int HOLD_TICKS = 4,
    parameter int SCAN_DIV   = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [N_POS-1:0] ball_pos,
    input  logic             left_hit,
    input  logic             right_hit,
    output logic             serve_left,
    output logic             serve_right,
    output logic [3:0]       score_left,
    output logic [3:0]       score_right,
    output logic             game_over,
    output logic             winner,
    output logic [3:0]       an,
    output logic [6:0]       seg
);

    localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);
    localparam logic [3:0]    WIN       = 4'(WIN_SCORE);

    state_t        state_reg, state_next;
    logic          left_ok_reg, left_ok_next;
    logic          right_ok_reg, right_ok_next;
    logic [HW-1:0] hold_reg, hold_next;
    logic          scorer_reg, scorer_next;
    logic [3:0]    score_left_reg, score_left_next;
    logic [3:0]    score_right_reg, score_right_next;
    logic          serve_left_reg, serve_left_next;
    logic          serve_right_reg, serve_right_next;
    logic          winner_reg, winner_next;

    logic at_left, at_right;
    logic left_flag, right_flag;
    logic point, point_side;
    logic hold_done;
    logic [3:0] scorer_score;

    // Only the two end positions matter to the referee.
    logic ball_mid_unused;
    assign ball_mid_unused = ^ball_pos;

    assign at_left  = ball_pos[0];
    assign at_right = ball_pos[N_POS-1];

    // A hit in the same cycle counts before the miss check; flags drop once
    // the ball is no longer at that end.
    assign left_flag  = at_left  & (left_ok_reg  | left_hit);
    assign right_flag = at_right & (right_ok_reg | right_hit);

    assign hold_done    = (hold_reg == '0) || (tick && hold_reg == HW'(1));
    assign scorer_score = (scorer_reg == SIDE_LEFT) ? score_left_reg : score_right_reg;

    // Next-state, scoring and serve decisions.
    always_comb begin
        state_next       = state_reg;
        left_ok_next     = left_ok_reg;
        right_ok_next    = right_ok_reg;
        hold_next        = hold_reg;
        scorer_next      = scorer_reg;
        score_left_next  = score_left_reg;
        score_right_next = score_right_reg;
        serve_left_next  = 1'b0;
        serve_right_next = 1'b0;
        winner_next      = winner_reg;
        point            = 1'b0;
        point_side       = SIDE_LEFT;

        case (state_reg)
            ST_IDLE: begin
                if (left_hit) begin
                    serve_left_next = 1'b1;
                    state_next      = ST_RALLY;
                    left_ok_next    = 1'b0;
                    right_ok_next   = 1'b0;
                end else if (right_hit) begin
                    serve_right_next = 1'b1;
                    state_next       = ST_RALLY;
                    left_ok_next     = 1'b0;
                    right_ok_next    = 1'b0;
                end
            end

            ST_RALLY: begin
                left_ok_next  = left_flag;
                right_ok_next = right_flag;
                if (tick && at_left && !left_flag) begin
                    point      = 1'b1;
                    point_side = SIDE_RIGHT;
                end else if (tick && at_right && !right_flag) begin
                    point      = 1'b1;
                    point_side = SIDE_LEFT;
                end else if (left_hit && !at_left) begin
                    point      = 1'b1;
                    point_side = SIDE_RIGHT;
                end else if (right_hit && !at_right) begin
                    point      = 1'b1;
                    point_side = SIDE_LEFT;
                end

                if (point) begin
                    state_next    = ST_POINT;
                    hold_next     = HOLD_LOAD;
                    scorer_next   = point_side;
                    left_ok_next  = 1'b0;
                    right_ok_next = 1'b0;
                    if (point_side == SIDE_LEFT) begin
                        score_left_next = (score_left_reg >= WIN) ? score_left_reg
                                                                  : score_left_reg + 4'd1;
                    end else begin
                        score_right_next = (score_right_reg >= WIN) ? score_right_reg
                                                                    : score_right_reg + 4'd1;
                    end
                end
            end

            ST_POINT: begin
                if (tick && hold_reg != '0) begin
                    hold_next = hold_reg - HW'(1);
                end
                if (hold_done) begin
                    if (scorer_score >= WIN) begin
                        state_next  = ST_OVER;
                        winner_next = scorer_reg;
                    end else begin
                        // The side that lost the point serves next.
                        state_next       = ST_RALLY;
                        left_ok_next     = 1'b0;
                        right_ok_next    = 1'b0;
                        serve_left_next  = (scorer_reg == SIDE_RIGHT);
                        serve_right_next = (scorer_reg == SIDE_LEFT);
                    end
                end
            end

            ST_OVER: begin
                state_next = ST_OVER;
            end

            default: state_next = ST_IDLE;
        endcase
    end

    // Referee state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            left_ok_reg     <= 1'b0;
            right_ok_reg    <= 1'b0;
            hold_reg        <= '0;
            scorer_reg      <= SIDE_LEFT;
            score_left_reg  <= 4'd0;
            score_right_reg <= 4'd0;
            serve_left_reg  <= 1'b0;
            serve_right_reg <= 1'b0;
            winner_reg      <= SIDE_LEFT;
        end else begin
            state_reg       <= state_next;
            left_ok_reg     <= left_ok_next;
            right_ok_reg    <= right_ok_next;
            hold_reg        <= hold_next;
            scorer_reg      <= scorer_next;
            score_left_reg  <= score_left_next;
            score_right_reg <= score_right_next;
            serve_left_reg  <= serve_left_next;
            serve_right_reg <= serve_right_next;
            winner_reg      <= winner_next;
        end
    end

    assign serve_left  = serve_left_reg;
    assign serve_right = serve_right_reg;
    assign score_left  = score_left_reg;
    assign score_right = score_right_reg;
    assign game_over   = (state_reg == ST_OVER);
    assign winner      = winner_reg;

    seg7_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk    (clk),
        .reset  (reset),
        .digit0 (units_code(score_right_reg)),
        .digit1 (tens_code(score_right_reg)),
        .digit2 (units_code(score_left_reg)),
        .digit3 (tens_code(score_left_reg)),
        .an     (an),
        .seg    (seg)
    );

endmodule

// File: tb/tb_tennis_referee.sv
// Scoreboard bench for tennis_referee: stimulus queues the expected serve /
// score / game-over events with their cycle stamps, a monitor pops and
// compares them; display and reset behaviour are checked directly.
module tb_tennis_referee;

    localparam int N_POS = 8;
    localparam int WIN   = 12;
    localparam int HOLD  = 4;
    localparam int SDIV  = 4;

    localparam logic [7:0] P0 = 8'h01;
    localparam logic [7:0] P3 = 8'h08;
    localparam logic [7:0] P7 = 8'h80;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [7:0] ball_pos;
    logic       left_hit;
    logic       right_hit;
    logic       serve_left;
    logic       serve_right;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       game_over;
    logic       winner;
    logic [3:0] an;
    logic [6:0] seg;

    tennis_referee #(
        .N_POS      (N_POS),
        .WIN_SCORE  (WIN),
        .HOLD_TICKS (HOLD),
        .SCAN_DIV   (SDIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .ball_pos    (ball_pos),
        .left_hit    (left_hit),
        .right_hit   (right_hit),
        .serve_left  (serve_left),
        .serve_right (serve_right),
        .score_left  (score_left),
        .score_right (score_right),
        .game_over   (game_over),
        .winner      (winner),
        .an          (an),
        .seg         (seg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       sl;
        logic       sr;
        logic [3:0] l;
        logic [3:0] r;
        logic       go;
        logic       w;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  fails  = 0;

    // Monitor: every serve pulse, score change or game_over change is an event.
    initial begin
        logic [3:0] prev_l;
        logic [3:0] prev_r;
        logic       prev_go;
        ev_t        e;
        prev_l  = 4'd0;
        prev_r  = 4'd0;
        prev_go = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_l  = score_left;
                prev_r  = score_right;
                prev_go = game_over;
            end else if (serve_left || serve_right || score_left != prev_l ||
                         score_right != prev_r || game_over != prev_go) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL event_unexpected cyc=%0d actual sl=%0b sr=%0b l=%0d r=%0d go=%0b w=%0b required none",
                             cyc, serve_left, serve_right, score_left, score_right, game_over, winner);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.sl !== serve_left || e.sr !== serve_right ||
                        e.l !== score_left || e.r !== score_right ||
                        e.go !== game_over || (e.go && e.w !== winner)) begin
                        fails++;
                        $display("FAIL event actual cyc=%0d sl=%0b sr=%0b l=%0d r=%0d go=%0b w=%0b required cyc=%0d sl=%0b sr=%0b l=%0d r=%0d go=%0b w=%0b",
                                 cyc, serve_left, serve_right, score_left, score_right, game_over, winner,
                                 e.cyc, e.sl, e.sr, e.l, e.r, e.go, e.w);
                    end
                end
                prev_l  = score_left;
                prev_r  = score_right;
                prev_go = game_over;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Apply one cycle of inputs; called at posedge+1, returns at next posedge+1.
    task automatic step(input logic t, input logic lh, input logic rh, input logic [7:0] pos);
        tick      = t;
        left_hit  = lh;
        right_hit = rh;
        ball_pos  = pos;
        @(posedge clk);
        #1;
    endtask

    // Expect an event caused by the inputs of the next step.
    task automatic expect_ev(input logic sl, input logic sr, input logic [3:0] l,
                             input logic [3:0] r, input logic go, input logic w);
        ev_t e;
        e.cyc = cyc + 1;
        e.sl  = sl;
        e.sr  = sr;
        e.l   = l;
        e.r   = r;
        e.go  = go;
        e.w   = w;
        exp_q.push_back(e);
    endtask

    // Hold period: paddle pulses between ticks are ignored; the last tick
    // produces the serve (or game over) event.
    task automatic hold_out(input logic sl, input logic sr, input logic [3:0] l,
                            input logic [3:0] r, input logic go);
        for (int i = 0; i < HOLD; i++) begin
            step(1'b0, 1'b1, 1'b1, P3);
            if (i == HOLD - 1) expect_ev(sl, sr, l, r, go, 1'b0);
            step(1'b1, 1'b0, 1'b0, P3);
        end
        step(1'b0, 1'b0, 1'b0, P3);
    endtask

    logic [3:0] exp_an  [4];
    logic [6:0] exp_seg [4];

    initial begin
        int n;
        reset     = 1'b1;
        tick      = 1'b0;
        left_hit  = 1'b0;
        right_hit = 1'b0;
        ball_pos  = P3;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_serve_left", {31'd0, serve_left}, 32'd0);
        check("rst_serve_right", {31'd0, serve_right}, 32'd0);
        check("rst_score_left", {28'd0, score_left}, 32'd0);
        check("rst_score_right", {28'd0, score_right}, 32'd0);
        check("rst_game_over", {31'd0, game_over}, 32'd0);
        check("rst_winner", {31'd0, winner}, 32'd0);
        check("rst_an", {28'd0, an}, 32'h0000000e);
        check("rst_seg", {25'd0, seg}, 32'h00000040);
        reset = 1'b0;

        // Idle, then left_hit serves from the left.
        step(1'b1, 1'b0, 1'b0, P0);
        step(1'b0, 1'b0, 1'b0, P3);
        expect_ev(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, P3);
        step(1'b0, 1'b0, 1'b0, P3);

        // Left miss: right scores, then left serves after the hold.
        expect_ev(1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, P0);
        hold_out(1'b1, 1'b0, 4'd0, 4'd1, 1'b0);

        // Right fault mid-court: left scores, right serves after the hold.
        expect_ev(1'b0, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, P3);
        hold_out(1'b0, 1'b1, 4'd1, 4'd1, 1'b0);

        // Hit and tick together at the left end: no point; flag persists
        // while the ball stays, clears once it leaves.
        step(1'b1, 1'b1, 1'b0, P0);
        step(1'b0, 1'b0, 1'b0, P0);
        step(1'b1, 1'b0, 1'b0, P0);
        step(1'b1, 1'b0, 1'b0, 8'h02);
        expect_ev(1'b0, 1'b0, 4'd1, 4'd2, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, P0);
        hold_out(1'b1, 1'b0, 4'd1, 4'd2, 1'b0);

        // Right return, then a miss takes priority over a simultaneous right fault.
        step(1'b0, 1'b0, 1'b1, P7);
        step(1'b1, 1'b0, 1'b0, P7);
        step(1'b1, 1'b0, 1'b0, 8'h40);
        expect_ev(1'b0, 1'b0, 4'd1, 4'd3, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, P0);
        hold_out(1'b1, 1'b0, 4'd1, 4'd3, 1'b0);

        // Both faults at once: the left fault wins.
        expect_ev(1'b0, 1'b0, 4'd1, 4'd4, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, P3);
        hold_out(1'b1, 1'b0, 4'd1, 4'd4, 1'b0);

        // Right-end miss: left scores.
        expect_ev(1'b0, 1'b0, 4'd2, 4'd4, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, P7);
        hold_out(1'b0, 1'b1, 4'd2, 4'd4, 1'b0);

        // Right faults drive the left player to WIN; last hold ends the game.
        for (int s = 3; s <= WIN; s++) begin
            expect_ev(1'b0, 1'b0, 4'(s), 4'd4, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b1, P3);
            if (s < WIN) hold_out(1'b0, 1'b1, 4'(s), 4'd4, 1'b0);
            else         hold_out(1'b0, 1'b0, 4'(s), 4'd4, 1'b1);
        end

        // Game over: all inputs ignored.
        step(1'b1, 1'b1, 1'b0, P0);
        step(1'b1, 1'b0, 1'b1, P7);
        step(1'b0, 1'b1, 1'b1, P3);
        step(1'b1, 1'b0, 1'b0, P0);
        check("over_score_left", {28'd0, score_left}, 32'd12);
        check("over_score_right", {28'd0, score_right}, 32'd4);
        check("over_game_over", {31'd0, game_over}, 32'd1);
        check("over_winner", {31'd0, winner}, 32'd0);

        // Display of 12 : 4.
        exp_an[0] = 4'b1110; exp_seg[0] = 7'b0011001;
        exp_an[1] = 4'b1101; exp_seg[1] = 7'b1111111;
        exp_an[2] = 4'b1011; exp_seg[2] = 7'b0100100;
        exp_an[3] = 4'b0111; exp_seg[3] = 7'b1111001;
        n = 0;
        while (an !== 4'b0111 && n < 40) begin @(negedge clk); n++; end
        while (an !== 4'b1110 && n < 80) begin @(negedge clk); n++; end
        if (n >= 80) begin
            checks++;
            fails++;
            $display("FAIL scan_align actual an=%b required an=1110 within 80 cycles", an);
        end
        for (int d = 0; d < 4; d++) begin
            check("scan_an", {28'd0, an}, {28'd0, exp_an[d]});
            check("scan_seg", {25'd0, seg}, {25'd0, exp_seg[d]});
            for (int k = 0; k < SDIV - 1; k++) begin
                @(negedge clk);
                check("scan_hold_an", {28'd0, an}, {28'd0, exp_an[d]});
            end
            @(negedge clk);
        end

        // Reset mid-scan clears display and game immediately.
        n = 0;
        while (an !== 4'b1011 && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) begin
            checks++;
            fails++;
            $display("FAIL scan_wait actual an=%b required an=1011 within 40 cycles", an);
        end
        #2 reset = 1'b1;
        #1;
        check("midscan_an", {28'd0, an}, 32'h0000000e);
        check("midscan_seg", {25'd0, seg}, 32'h00000040);
        check("midscan_score_left", {28'd0, score_left}, 32'd0);
        check("midscan_game_over", {31'd0, game_over}, 32'd0);
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 1'b0, P3);
        reset = 1'b0;

        // Both paddles in IDLE: left serves.
        expect_ev(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, P3);
        step(1'b0, 1'b0, 1'b0, P3);

        // Reset mid-rally: no serve during or after.
        reset = 1'b1;
        #1;
        check("midrally_serve_left", {31'd0, serve_left}, 32'd0);
        step(1'b1, 1'b1, 1'b1, P0);
        step(1'b0, 1'b1, 1'b0, P7);
        check("midrally_serve_left2", {31'd0, serve_left}, 32'd0);
        check("midrally_serve_right", {31'd0, serve_right}, 32'd0);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, P3);
        step(1'b1, 1'b0, 1'b0, P0);

        // Right serve from IDLE, left fault, then reset mid-hold.
        expect_ev(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, P3);
        expect_ev(1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, P3);
        step(1'b1, 1'b0, 1'b0, P3);
        step(1'b1, 1'b0, 1'b0, P3);
        reset = 1'b1;
        #1;
        check("midhold_score_right", {28'd0, score_right}, 32'd0);
        step(1'b1, 1'b0, 1'b0, P3);
        step(1'b1, 1'b0, 1'b0, P3);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, P3);

        // Every queued event must have been seen.
        repeat (3) step(1'b0, 1'b0, 1'b0, P3);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/tennis_referee.md
# tennis_referee

Scoring and display end of the tennis game: it consumes the ball position produced by the ball mover and the debounced paddle pulses, and decides hits, misses and faults. It keeps both scores, issues serve requests back to the ball mover and drives a multiplexed 4-digit seven-segment display. It runs on the board clock beside the Debouncers; ball-step timing arrives as a one-cycle strobe.

## Interface
- N_POS, 8, number of ball positions; position 0 is the left end, N_POS-1 the right end
- WIN_SCORE, 7, points needed to win (1..15)
- HOLD_TICKS, 4, ticks the game pauses after a point
- SCAN_DIV, 50000, clk cycles per display digit
- clk  in  1  board clock
- reset  in  1  asynchronous, active-high; clears all state
- tick  in  1  one-cycle strobe, ball advances on this cycle
- ball_pos  in  N_POS  one-hot ball position, valid every cycle
- left_hit  in  1  debounced left paddle pulse (one cycle)
- right_hit  in  1  debounced right paddle pulse (one cycle)
- serve_left  out  1  one-cycle pulse: launch ball from left end
- serve_right  out  1  one-cycle pulse: launch ball from right end
- score_left  out  4  left player points
- score_right  out  4  right player points
- game_over  out  1  high once a player reaches WIN_SCORE
- winner  out  1  0 = left, 1 = right; valid while game_over
- an  out  4  digit enables, active-low
- seg  out  7  segments gfedcba, active-low

## Operation
- FSM states: IDLE, RALLY, POINT, OVER. Reset -> IDLE.
- IDLE: first left_hit (or right_hit) -> serve_left (or serve_right) pulse, go to RALLY. If both arrive in the same cycle, left wins.
- RALLY, hit window flags left_ok and right_ok:
  - left_hit with ball_pos[0]=1 sets left_ok; right_hit with ball_pos[N_POS-1]=1 sets right_ok.
  - A flag clears when the ball leaves that end.
- RALLY, point events, in priority order (at most one point per cycle):
  - (1) tick with ball_pos[0]=1 and left_ok=0 -> right scores; tick with ball_pos[N_POS-1]=1 and right_ok=0 -> left scores.
  - (2) left_hit while ball_pos[0]=0 is a left fault -> right scores.
  - (3) right_hit while ball_pos[N_POS-1]=0 is a right fault -> left scores.
- On a point: increment the scorer's count and go to POINT with hold counter = HOLD_TICKS.
- POINT:
  - Each tick decrements the hold counter; paddle pulses are ignored.
  - When the counter reaches 0: if the scorer's count equals WIN_SCORE, go to OVER and set winner; otherwise emit a serve pulse from the side that lost the point and return to RALLY with both flags clear.
- OVER: game_over=1, scores frozen, all inputs ignored. Only reset leaves this state.
- Scores saturate at WIN_SCORE and never wrap.
- Display:
  - Digits 3,2 show score_left in decimal (tens, units); digits 1,0 show score_right.
  - A tens digit of 0 is blanked.
  - The scan counter counts 0..SCAN_DIV-1; on wrap, the active digit advances 0->1->2->3->0.

## Timing
- Reset values: all outputs 0 except an=4'b1110 and seg = pattern for '0' (7'b1000000); winner=0.
- Serve pulse is registered: it is high for exactly the cycle after the triggering event.
- A score changes on the clk edge after the tick or fault cycle. game_over rises on the cycle after the final POINT tick.
- A hit and a tick in the same cycle: the hit sets the flag before the miss check, so the hit counts.
- Reset mid-rally or mid-hold aborts immediately. No serve pulse is emitted during or after reset.
- an and seg change only on scan wrap. Both are registered, so they are glitch-free.

## Structure
- Shared package tennis_pkg holds:
  - the state encoding (ST_IDLE, ST_RALLY, ST_POINT, ST_OVER, 2 bits)
  - the seven-segment constants for digits 0-9 and blank
  - the LEFT/RIGHT side constants
- One sub-module: seg7_scan, which takes four 4-bit digit codes and drives an/seg with the scan counter. The referee FSM and score logic stay in tennis_referee.

## Test plan
- Reset, then left_hit -> serve_left high one cycle, state RALLY, scores 0/0.
- Ball at position 0, tick with no prior left_hit -> score_right=1 next cycle; after 4 ticks, serve_left pulse.
- Ball at position 3, right_hit -> right fault; score_left increments by 1, no serve until HOLD_TICKS elapse.
- left_hit and tick in the same cycle with ball_pos=8'b00000001 -> no point awarded, rally continues.
- Drive the left player to 7 points -> game_over=1 and winner=0; subsequent hits and ticks leave the scores unchanged.
- score_left=12 with SCAN_DIV=4 -> an cycles 1110,1101,1011,0111 every 4 clocks; the digit 3 seg pattern is '1' and digit 2 is '2'. Reset mid-scan -> an=1110 immediately.
